// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared types and sizing for the byte-serial multiplier front-end
package mul_seq_pkg;
    typedef enum logic [1:0] {LOAD, ISSUE, WAIT, DRAIN} state_t;
    localparam int OP_W       = 32;
    localparam int OP_BYTES   = OP_W / 8;
    localparam int PROD_BYTES = 2 * OP_BYTES;
    localparam int LAT_CNT_W  = 4;
endpackage

// File: rtl/mul_byte_unpacker.sv
// mul_byte_unpacker: byte-serial shift register, first byte written lands in the lowest byte
module mul_byte_unpacker #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           we,
    input  logic [7:0]     din,
    output logic [8*N-1:0] assembled
);
    logic [8*(N-1)-1:0] sh;
    // assembled already includes the byte being written, so the last byte needs no extra cycle
    assign assembled = {din, sh};
    always_ff @(posedge clk) begin
        if (!rst_n)
            sh <= '0;
        else if (we)
            sh <= assembled[8*N-1:8];
    end
endmodule

// File: rtl/mul_io_sequencer.sv
// mul_io_sequencer: collects two operands byte-wise, issues one multiply, drains the product byte-wise
module mul_io_sequencer
    import mul_seq_pkg::*;
#(
    parameter int MUL_LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    output logic              mul_in_valid,
    input  logic [2*OP_W-1:0] mul_p,
    output logic              busy
);
    localparam int KW = $clog2(PROD_BYTES);
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MUL_LATENCY - 1);
    state_t state, state_nx;
    logic [KW-1:0] k;
    logic [LAT_CNT_W-1:0] lat;
    logic [2*OP_W-1:0] prod, ops_nx;
    logic in_fire, out_fire, last_byte;
    assign in_fire   = in_valid && in_ready && ena;
    assign out_fire  = out_valid && out_ready && ena;
    assign last_byte = k == KW'(PROD_BYTES - 1);
    mul_byte_unpacker #(.N(PROD_BYTES)) u_unpacker (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (in_fire),
        .din       (in_data),
        .assembled (ops_nx)
    );
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= LOAD;
        else if (ena)
            state <= state_nx;
    end
    always_comb begin
        state_nx = state == LOAD  ? (in_fire && last_byte ? ISSUE : LOAD) :
                   state == ISSUE ? WAIT :
                   state == WAIT  ? (lat == '0 ? DRAIN : WAIT) :
                                    (out_fire && last_byte ? LOAD : DRAIN);
    end
    always_comb begin
        out_valid    = state == DRAIN;
        busy         = state != LOAD;
        mul_in_valid = state == ISSUE && ena;
        out_data     = out_valid ? prod[{k, 3'b000} +: 8] : 8'h00;
    end
    // in_ready tracks the next state so it is a flop that always equals (state == LOAD)
    always_ff @(posedge clk) begin
        if (!rst_n)
            in_ready <= 1'b1;
        else if (ena)
            in_ready <= state_nx == LOAD;
    end
    // k serves both the load and the drain phase and wraps to 0 after the last byte
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k     <= '0;
            lat   <= '0;
            prod  <= '0;
            mul_a <= '0;
            mul_b <= '0;
        end else if (ena) begin
            if (in_fire || out_fire)
                k <= k + 1'b1;
            if (in_fire && last_byte)
                {mul_b, mul_a} <= ops_nx;
            if (state == ISSUE)
                lat <= LAT_LOAD;
            else if (state == WAIT && lat != '0)
                lat <= lat - 1'b1;
            if (state == WAIT && lat == '0)
                prod <= mul_p;
        end
    end
endmodule
